instruction_fetch: RTL and testbench

Front end of the vector ASIP pipeline and the producer of the 16-bit instruction word consumed by the decode stage. Holds the program counter, drives a synchronous instruction ROM with one-cycle read latency, registers the returned word into the fetch/decode pipeline register, and handles stall back-pressure, branch redirect and program halt. Output format is the decode format: opcode [15:12], register [11:8], immediate [7:0].

---
 rtl/instruction_fetch_if.sv | 28 ++
 rtl/instruction_fetch.sv | 133 +++++++++++++
 tb/tb_instruction_fetch.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Signal bundle between the fetch stage and its environment:
// pipeline control, the synchronous ROM read port, and the fetch/decode register outputs.
interface instruction_fetch_if #(
  parameter int N      = 16,
  parameter int ADDR_W = 8
);
  logic              Enable;
  logic              Stall;
  logic              BranchTaken;
  logic [ADDR_W-1:0] BranchTarget;
  logic [N-1:0]      InstrData;
  logic              InstrReq;
  logic [ADDR_W-1:0] InstrAddr;
  logic [N-1:0]      Instruction;
  logic [ADDR_W-1:0] InstrPC;
  logic              InstrValid;
  logic              Halted;

  modport master (
    input  Enable, Stall, BranchTaken, BranchTarget, InstrData,
    output InstrReq, InstrAddr, Instruction, InstrPC, InstrValid, Halted
  );

  modport slave (
    output Enable, Stall, BranchTaken, BranchTarget, InstrData,
    input  InstrReq, InstrAddr, Instruction, InstrPC, InstrValid, Halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, one-cycle-latency ROM requests, fetch/decode output register,
// 1-entry skid buffer for stall back-pressure, branch redirect and halt on HALT_WORD.
module instruction_fetch #(
  parameter int           N         = 16,
  parameter int           ADDR_W    = 8,
  parameter logic [N-1:0] HALT_WORD = N'(16'hFFFF)
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              req_q;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic              skid_valid;
  logic [N-1:0]      skid_word;
  logic [ADDR_W-1:0] skid_pc;
  logic [N-1:0]      instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              valid_q;
  logic              halted_q;

  logic              req_fire;
  logic              halt_pending;
  logic              load_valid;
  logic [N-1:0]      load_word;
  logic [ADDR_W-1:0] load_pc;

  // Request is masked in stalled cycles, so at most one word is ever in flight at a stall.
  assign req_fire     = req_q & ~bus.Stall;
  assign halt_pending = valid_q && (instr_q == HALT_WORD);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    load_valid = 1'b0;
    load_word  = bus.InstrData;
    load_pc    = inflight_pc;
    if (skid_valid) begin
      load_valid = 1'b1;
      load_word  = skid_word;
      load_pc    = skid_pc;
    end else if (inflight) begin
      load_valid = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset clears every
  // register including the skid storage, so a mid-run reset leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      req_q       <= 1'b0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      skid_valid  <= 1'b0;
      skid_word   <= '0;
      skid_pc     <= '0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Enable) begin
            state <= RUN;
            req_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.BranchTaken) begin
            pc         <= bus.BranchTarget;
            req_q      <= 1'b1;
            inflight   <= 1'b0;
            skid_valid <= 1'b0;
            valid_q    <= 1'b0;
          end else if (halt_pending) begin
            inflight   <= 1'b0;
            skid_valid <= 1'b0;
            if (!bus.Stall) begin
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
              state    <= HALT;
            end
          end else begin
            inflight    <= req_fire;
            inflight_pc <= pc;
            if (req_fire) pc <= pc + ADDR_W'(1);
            if (bus.Stall) begin
              if (inflight) begin
                skid_valid <= 1'b1;
                skid_word  <= bus.InstrData;
                skid_pc    <= inflight_pc;
              end
            end else begin
              valid_q <= load_valid;
              if (load_valid) begin
                instr_q    <= load_word;
                instr_pc_q <= load_pc;
              end
              if (skid_valid) begin
                skid_valid <= inflight;
                skid_word  <= bus.InstrData;
                skid_pc    <= inflight_pc;
              end
              // Halt word accepted: stop requesting and drop anything already fetched behind it.
              if (load_valid && (load_word == HALT_WORD)) begin
                req_q      <= 1'b0;
                inflight   <= 1'b0;
                skid_valid <= 1'b0;
              end
            end
          end
        end
        default: ;  // HALT is sticky until reset
      endcase
    end
  end

  assign bus.InstrReq    = req_fire;
  assign bus.InstrAddr   = pc;
  assign bus.Instruction = instr_q;
  assign bus.InstrPC     = instr_pc_q;
  assign bus.InstrValid  = valid_q;
  assign bus.Halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed start/stall/branch/wrap/halt/reset sequences plus a
// randomized stall/branch run, all checked by a program-order scoreboard.
module tb_instruction_fetch;

  localparam logic [15:0] HALT = 16'hFFFF;

  typedef struct packed {
    logic [15:0] word;
    logic [7:0]  pc;
  } item_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] rom [256];

  instruction_fetch_if #(.N(16), .ADDR_W(8)) bus ();

  instruction_fetch #(.N(16), .ADDR_W(8), .HALT_WORD(16'hFFFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM with one-cycle read latency
  always @(posedge clk) if (bus.InstrReq) bus.InstrData <= rom[bus.InstrAddr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model: expected program-order stream ----------------
  item_t exp_q[$];
  int    m_state;       // 0 idle, 1 running, 2 halted
  bit    m_halt_shown;  // halt word has been presented
  bit    e_stall;
  bit    e_br;

  function automatic void load_stream(input logic [7:0] start);
    logic [7:0] a;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      a = start + 8'(i);
      exp_q.push_back(item_t'{word: rom[a], pc: a});
      if (rom[a] == HALT) break;
    end
  endfunction

  initial begin
    m_state = 0; m_halt_shown = 0; e_stall = 0; e_br = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_state = 0; m_halt_shown = 0; e_stall = 0; e_br = 0;
        exp_q.delete();
      end else begin
        e_stall = bus.Stall;
        e_br    = bus.BranchTaken;
        if (m_state == 0) begin
          if (bus.Enable) begin
            m_state = 1;
            load_stream(8'h00);
          end
        end else if (m_state == 1) begin
          if (bus.BranchTaken) begin
            load_stream(bus.BranchTarget);
            m_halt_shown = 0;
          end else if (m_halt_shown && !bus.Stall) begin
            m_state = 2;
            m_halt_shown = 0;
          end
        end
      end
    end
  end

  // ---------------- monitor: compares presented words with the expected stream ----------------
  initial begin
    logic        p_valid;
    logic [15:0] p_instr;
    logic [7:0]  p_pc;
    item_t       it;
    p_valid = 0; p_instr = 0; p_pc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_valid = 0; p_instr = 0; p_pc = 0;
      end else begin
        check("halted_flag", 48'(bus.Halted), 48'(m_state == 2));
        if (m_state == 2) check("halted_quiet", 48'({bus.InstrValid, bus.InstrReq}), 48'(0));
        if (bus.Stall) check("stall_no_req", 48'(bus.InstrReq), 48'(0));
        if (e_stall && !(e_br && m_state == 1)) begin
          check("stall_hold", 48'({bus.InstrValid, bus.Instruction, bus.InstrPC}),
                48'({p_valid, p_instr, p_pc}));
        end else if (bus.InstrValid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL stream_extra: got %h@%h, required no valid word (t=%0t)",
                     bus.Instruction, bus.InstrPC, $time);
          end else begin
            it = exp_q.pop_front();
            check("stream", 48'({bus.Instruction, bus.InstrPC}), 48'({it.word, it.pc}));
            if (it.word == HALT) begin
              m_halt_shown = 1;
              check("halt_req_drop", 48'(bus.InstrReq), 48'(0));
            end
          end
        end
        p_valid = bus.InstrValid; p_instr = bus.Instruction; p_pc = bus.InstrPC;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.Enable = 0; bus.Stall = 0; bus.BranchTaken = 0; bus.BranchTarget = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Pulses Enable; returns just after the edge that presents ROM[0]
  task automatic start();
    bus.Enable = 1'b1;
    cyc();
    bus.Enable = 1'b0;
    cyc(); cyc();
  endtask

  task automatic expect_out(input string name, input logic [15:0] w, input logic [7:0] a);
    check(name, 48'({bus.InstrValid, bus.Instruction, bus.InstrPC}), 48'({1'b1, w, a}));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.Enable = 0; bus.Stall = 0; bus.BranchTaken = 0; bus.BranchTarget = '0;
    bus.InstrData = '0;
    fill_seq();
    repeat (3) cyc();
    check("reset_ctrl", 48'({bus.InstrReq, bus.InstrValid, bus.Halted, bus.InstrAddr}), 48'(0));
    check("reset_data", 48'({bus.Instruction, bus.InstrPC}), 48'(0));
    rst_n = 1'b1;
    cyc();

    // start-up latency and steady stream
    bus.Enable = 1'b1;
    cyc();
    bus.Enable = 1'b0;
    check("start_req", 48'({bus.InstrReq, bus.InstrAddr, bus.InstrValid}), 48'({1'b1, 8'h00, 1'b0}));
    cyc();
    check("start_bubble", 48'(bus.InstrValid), 48'(0));
    cyc(); expect_out("first_word", 16'h1000, 8'h00);
    cyc(); expect_out("word1", 16'h1001, 8'h01);
    cyc(); expect_out("word2", 16'h1002, 8'h02);
    cyc(); expect_out("word3", 16'h1003, 8'h03);

    // stall for three cycles while 1003 is shown
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_out("stall_held", 16'h1003, 8'h03);
      check("stall_req_low", 48'(bus.InstrReq), 48'(0));
    end
    bus.Stall = 1'b0;
    cyc(); expect_out("skid_word", 16'h1004, 8'h04);
    cyc(); expect_out("after_skid", 16'h1005, 8'h05);

    // branch while 1005 shown
    bus.BranchTaken = 1'b1; bus.BranchTarget = 8'h40;
    cyc();
    bus.BranchTaken = 1'b0;
    check("br_bubble0", 48'(bus.InstrValid), 48'(0));
    cyc(); check("br_bubble1", 48'(bus.InstrValid), 48'(0));
    cyc(); expect_out("br_target", 16'h1040, 8'h40);

    // branch together with stall
    bus.BranchTaken = 1'b1; bus.Stall = 1'b1; bus.BranchTarget = 8'h80;
    cyc();
    bus.BranchTaken = 1'b0; bus.Stall = 1'b0;
    check("brst_bubble0", 48'(bus.InstrValid), 48'(0));
    cyc(); check("brst_bubble1", 48'(bus.InstrValid), 48'(0));
    cyc(); expect_out("brst_target", 16'h1080, 8'h80);

    // PC wrap
    bus.BranchTaken = 1'b1; bus.BranchTarget = 8'hFE;
    cyc();
    bus.BranchTaken = 1'b0;
    cyc(); cyc(); expect_out("wrap_fe", 16'h10FE, 8'hFE);
    cyc(); expect_out("wrap_ff", 16'h10FF, 8'hFF);
    cyc(); expect_out("wrap_00", 16'h1000, 8'h00);
    cyc(); expect_out("wrap_01", 16'h1001, 8'h01);

    // randomized stall / branch traffic over random program contents
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'($urandom);
      if (rom[i] == HALT) rom[i] = 16'h0000;
    end
    do_reset();
    bus.Enable = 1'b1;
    cyc();
    bus.Enable = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bus.Stall        = ($urandom_range(0, 99) < 30);
      bus.BranchTaken  = ($urandom_range(0, 99) < 5);
      bus.BranchTarget = 8'($urandom);
      cyc();
    end
    bus.Stall = 1'b0; bus.BranchTaken = 1'b0;
    repeat (6) cyc();

    // halt without stall, then ignored branch and enable
    rst_n = 1'b0;
    fill_seq(); rom[3] = HALT;
    do_reset();
    start();
    cyc(); cyc();
    cyc(); expect_out("halt_shown", HALT, 8'h03);
    check("halt_shown_req", 48'(bus.InstrReq), 48'(0));
    cyc();
    check("halt_taken", 48'({bus.Halted, bus.InstrValid, bus.InstrReq}), 48'({1'b1, 1'b0, 1'b0}));
    bus.BranchTaken = 1'b1; bus.BranchTarget = 8'h20; bus.Enable = 1'b1;
    cyc();
    bus.BranchTaken = 1'b0; bus.Enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("halt_sticky", 48'({bus.Halted, bus.InstrValid, bus.InstrReq}), 48'({1'b1, 1'b0, 1'b0}));
    end

    // halt held off by stall
    do_reset();
    start();
    cyc(); cyc(); cyc();
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("halt_stalled", 48'({bus.Halted, bus.InstrValid, bus.Instruction}), 48'({1'b0, 1'b1, HALT}));
    end
    bus.Stall = 1'b0;
    cyc();
    check("halt_after_stall", 48'({bus.Halted, bus.InstrValid}), 48'({1'b1, 1'b0}));

    // branch in the halt acceptance cycle squashes the halt
    do_reset();
    start();
    cyc(); cyc(); cyc();
    bus.BranchTaken = 1'b1; bus.BranchTarget = 8'h10;
    cyc();
    bus.BranchTaken = 1'b0;
    check("halt_squash", 48'({bus.Halted, bus.InstrValid}), 48'(0));
    cyc(); check("squash_bubble", 48'(bus.InstrValid), 48'(0));
    cyc(); expect_out("squash_target", 16'h1010, 8'h10);
    cyc(); expect_out("squash_next", 16'h1011, 8'h11);

    // asynchronous reset mid-stall with the skid entry occupied
    rst_n = 1'b0;
    fill_seq();
    do_reset();
    start();
    cyc(); cyc();
    bus.Stall = 1'b1;
    cyc();
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", 48'({bus.InstrReq, bus.InstrValid, bus.Halted, bus.InstrAddr}), 48'(0));
    check("async_rst_data", 48'({bus.Instruction, bus.InstrPC}), 48'(0));
    bus.Stall = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    start();
    expect_out("restart_first", 16'h1000, 8'h00);
    cyc(); expect_out("restart_next", 16'h1001, 8'h01);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
